// File: rtl/calc_pkg.sv
// Shared definitions for the sequential calculator: key-symbol codes,
// operator and state encodings, and small symbol-classification helpers.
package calc_pkg;

  // Key-symbol codes as delivered by the UI symbol FIFO (0-9 are digits)
  localparam logic [3:0] SYM_ADD = 4'hA;
  localparam logic [3:0] SYM_SUB = 4'hB;
  localparam logic [3:0] SYM_MUL = 4'hC;
  localparam logic [3:0] SYM_DIV = 4'hD;
  localparam logic [3:0] SYM_EQ  = 4'hE;
  localparam logic [3:0] SYM_CLR = 4'hF;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_N1   = 3'd1,
    S_OP   = 3'd2,
    S_N2   = 3'd3,
    S_CALC = 3'd4,
    S_FIN  = 3'd5,
    S_ERR  = 3'd6
  } state_e;

  function automatic logic is_digit(input logic [3:0] sym);
    return (sym <= 4'd9);
  endfunction

  function automatic logic is_op(input logic [3:0] sym);
    return (sym >= SYM_ADD) && (sym <= SYM_DIV);
  endfunction

  function automatic op_e sym_to_op(input logic [3:0] sym);
    case (sym)
      SYM_SUB: return OP_SUB;
      SYM_MUL: return OP_MUL;
      SYM_DIV: return OP_DIV;
      default: return OP_ADD;
    endcase
  endfunction

  // True when an operand already holds the maximum number of digits,
  // so one more digit key is an entry error.
  function automatic logic digit_limit_hit(input int count, input int maxd);
    return (count >= maxd);
  endfunction

endpackage

// File: rtl/calc_seq_alu.sv
// Arithmetic unit for the calculator. Add/subtract finish in the first
// cycle after start; multiply (shift-add) and divide (restoring) take
// exactly W cycles. Results are presented combinationally while o_done
// is high, which is the final cycle of the operation.
module calc_seq_alu
  import calc_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  op_e          i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_done,
  output logic [W-1:0] o_q,
  output logic         o_neg,
  output logic         o_ovf,
  output logic         o_div0
);

  localparam int CW = $clog2(W);

  logic          r_active;
  op_e           r_op;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W:0]    r_hi;   // mult: running upper product; div: partial remainder
  logic [W-1:0]  r_lo;   // mult: multiplier/low product; div: dividend/quotient

  logic [W:0]    w_sum;
  logic [W:0]    w_mul_acc;
  logic [W:0]    w_shift;
  logic [W:0]    w_diff;
  logic [W:0]    w_hi_next;
  logic [W-1:0]  w_lo_next;
  logic          w_last;

  assign w_last = (r_cnt == CW'(W - 1));

  // One iteration step of the multi-cycle operations, plus the add result
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_sum     = {1'b0, r_a} + {1'b0, r_b};
    w_mul_acc = r_hi + (r_lo[0] ? {1'b0, r_a} : '0);
    w_shift   = {r_hi[W-1:0], r_lo[W-1]};
    w_diff    = w_shift - {1'b0, r_b};
    w_hi_next = r_hi;
    w_lo_next = r_lo;
    case (r_op)
      OP_MUL: begin
        w_hi_next = {1'b0, w_mul_acc[W:1]};
        w_lo_next = {w_mul_acc[0], r_lo[W-1:1]};
      end
      OP_DIV: begin
        // Remainder stays below the divisor, so bit W of the difference is a clean borrow flag
        if (!w_diff[W]) begin
          w_hi_next = w_diff;
          w_lo_next = {r_lo[W-2:0], 1'b1};
        end else begin
          w_hi_next = w_shift;
          w_lo_next = {r_lo[W-2:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  // Result and completion flags for the operation in flight
  always_comb begin
    o_done = 1'b0;
    o_q    = '0;
    o_neg  = 1'b0;
    o_ovf  = 1'b0;
    o_div0 = 1'b0;
    if (r_active) begin
      case (r_op)
        OP_ADD: begin
          o_done = 1'b1;
          o_q    = w_sum[W-1:0];
          o_ovf  = w_sum[W];
        end
        OP_SUB: begin
          o_done = 1'b1;
          o_neg  = (r_b > r_a);
          o_q    = (r_b > r_a) ? (r_b - r_a) : (r_a - r_b);
        end
        OP_MUL: begin
          o_done = w_last;
          o_q    = w_lo_next;
          o_ovf  = |w_hi_next;
        end
        default: begin
          o_done = w_last;
          o_q    = w_lo_next;
          o_div0 = (r_b == '0);
        end
      endcase
    end
  end

  // Operand capture on start, then one iteration per cycle until done
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_active <= 1'b0;
      r_op     <= OP_ADD;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_op     <= i_op;
      r_cnt    <= '0;
      r_a      <= i_a;
      r_b      <= i_b;
      r_hi     <= '0;
      r_lo     <= (i_op == OP_MUL) ? i_b : i_a;
    end else if (r_active) begin
      r_hi  <= w_hi_next;
      r_lo  <= w_lo_next;
      r_cnt <= r_cnt + CW'(1);
      if (o_done) r_active <= 1'b0;
    end
  end

endmodule

// File: rtl/calc_seq_engine.sv
// Calculator core between the key-symbol FIFO and the result display.
// Pops symbols at most every other cycle, assembles decimal operands,
// runs one binary operation through calc_seq_alu and holds the result
// so the next expression can chain from it.
module calc_seq_engine
  import calc_pkg::*;
#(
  parameter int W    = 8,
  parameter int MAXD = 3
) (
  input  logic         CLK_50M,
  input  logic         reset,
  input  logic         sym_emp,
  input  logic [3:0]   sym_data,
  output logic         sym_rd,
  output logic [W-1:0] res,
  output logic         res_neg,
  output logic         res_valid,
  output logic         err,
  output logic         busy
);

  localparam int DW = $clog2(MAXD + 1);
  localparam int XW = W + 4;

  state_e        r_state, w_state_next;
  logic [W-1:0]  r_acc, w_acc_next;
  logic [DW-1:0] r_ndig, w_ndig_next;
  logic [W-1:0]  r_a, w_a_next;
  op_e           r_op, w_op_next;
  logic [W-1:0]  r_res, w_res_next;
  logic          r_neg, w_neg_next;
  logic          r_rd_prev;
  logic          r_valid;
  logic          r_err;
  logic          r_busy;

  logic          w_pop;
  logic          w_digit;
  logic          w_op_sym;
  logic          w_digit_err;
  logic          w_alu_start;
  logic [XW-1:0] w_acc_ext;
  logic          w_alu_done;
  logic [W-1:0]  w_alu_q;
  logic          w_alu_neg;
  logic          w_alu_ovf;
  logic          w_alu_div0;

  // The pop is gated by the previous pop so the FIFO sees at most one read every two cycles
  assign w_pop       = !reset && !sym_emp && (r_state != S_CALC) && !r_rd_prev;
  assign sym_rd      = w_pop;
  assign w_digit     = is_digit(sym_data);
  assign w_op_sym    = is_op(sym_data);
  assign w_acc_ext   = XW'(r_acc) * XW'(10) + XW'(sym_data);
  assign w_digit_err = digit_limit_hit(32'(r_ndig), MAXD) || (|w_acc_ext[XW-1:W]);

  calc_seq_alu #(.W(W)) u_alu (
    .i_clk   (CLK_50M),
    .i_reset (reset),
    .i_start (w_alu_start),
    .i_op    (r_op),
    .i_a     (r_a),
    .i_b     (r_acc),
    .o_done  (w_alu_done),
    .o_q     (w_alu_q),
    .o_neg   (w_alu_neg),
    .o_ovf   (w_alu_ovf),
    .o_div0  (w_alu_div0)
  );

  // Entry FSM: next state and next datapath values from the popped symbol
  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_ndig_next  = r_ndig;
    w_a_next     = r_a;
    w_op_next    = r_op;
    w_res_next   = r_res;
    w_neg_next   = r_neg;
    w_alu_start  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          if (w_digit) begin
            w_state_next = S_N1;
            w_acc_next   = W'(sym_data);
            w_ndig_next  = DW'(1);
          end else if (w_op_sym) begin
            w_state_next = S_ERR;
          end
        end
      end
      S_N1: begin
        if (w_pop) begin
          if (w_digit) begin
            if (w_digit_err) begin
              w_state_next = S_ERR;
            end else begin
              w_acc_next  = w_acc_ext[W-1:0];
              w_ndig_next = r_ndig + DW'(1);
            end
          end else if (w_op_sym) begin
            w_state_next = S_OP;
            w_a_next     = r_acc;
            w_op_next    = sym_to_op(sym_data);
          end else if (sym_data == SYM_EQ) begin
            w_state_next = S_FIN;
            w_res_next   = r_acc;
            w_neg_next   = 1'b0;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      S_OP: begin
        if (w_pop) begin
          if (w_op_sym) begin
            w_op_next = sym_to_op(sym_data);
          end else if (w_digit) begin
            w_state_next = S_N2;
            w_acc_next   = W'(sym_data);
            w_ndig_next  = DW'(1);
          end else if (sym_data == SYM_EQ) begin
            w_state_next = S_ERR;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      S_N2: begin
        if (w_pop) begin
          if (w_digit) begin
            if (w_digit_err) begin
              w_state_next = S_ERR;
            end else begin
              w_acc_next  = w_acc_ext[W-1:0];
              w_ndig_next = r_ndig + DW'(1);
            end
          end else if (sym_data == SYM_EQ) begin
            // r_acc is the second operand; the ALU captures it on this edge
            w_state_next = S_CALC;
            w_alu_start  = 1'b1;
          end else if (w_op_sym) begin
            w_state_next = S_ERR;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      S_CALC: begin
        if (w_alu_done) begin
          if (w_alu_ovf || w_alu_div0) begin
            w_state_next = S_ERR;
          end else begin
            w_state_next = S_FIN;
            w_res_next   = w_alu_q;
            w_neg_next   = w_alu_neg;
          end
        end
      end
      S_FIN: begin
        if (w_pop) begin
          if (w_digit) begin
            w_state_next = S_N1;
            w_acc_next   = W'(sym_data);
            w_ndig_next  = DW'(1);
          end else if (w_op_sym) begin
            // A negative result cannot be represented as an operand magnitude
            if (r_neg) begin
              w_state_next = S_ERR;
            end else begin
              w_state_next = S_OP;
              w_a_next     = r_res;
              w_op_next    = sym_to_op(sym_data);
            end
          end else if (sym_data == SYM_CLR) begin
            w_state_next = S_IDLE;
          end
        end
      end
      S_ERR: begin
        if (w_pop && (sym_data == SYM_CLR)) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (w_state_next == S_ERR) begin
      w_res_next = '0;
      w_neg_next = 1'b0;
    end
  end

  // State register
  always_ff @(posedge CLK_50M) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Datapath registers and registered status outputs decoded from the next state
  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      r_acc     <= '0;
      r_ndig    <= '0;
      r_a       <= '0;
      r_op      <= OP_ADD;
      r_res     <= '0;
      r_neg     <= 1'b0;
      r_rd_prev <= 1'b1;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_acc     <= w_acc_next;
      r_ndig    <= w_ndig_next;
      r_a       <= w_a_next;
      r_op      <= w_op_next;
      r_res     <= w_res_next;
      r_neg     <= w_neg_next;
      r_rd_prev <= w_pop;
      r_valid   <= (w_state_next == S_FIN);
      r_err     <= (w_state_next == S_ERR);
      r_busy    <= (w_state_next == S_CALC);
    end
  end

  assign res       = r_res;
  assign res_neg   = r_neg;
  assign res_valid = r_valid;
  assign err       = r_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_calc_seq_engine.sv
// Directed bench for calc_seq_engine (W=8, MAXD=3): a symbol FIFO model
// feeds key strings, and results, latency and busy length are compared
// against hand-computed values.
module tb_calc_seq_engine;

  localparam int W    = 8;
  localparam int MAXD = 3;

  logic         CLK_50M  = 1'b0;
  logic         reset    = 1'b1;
  logic         sym_emp  = 1'b1;
  logic [3:0]   sym_data = 4'h0;
  logic         sym_rd;
  logic [W-1:0] res;
  logic         res_neg;
  logic         res_valid;
  logic         err;
  logic         busy;

  calc_seq_engine #(.W(W), .MAXD(MAXD)) dut (
    .CLK_50M   (CLK_50M),
    .reset     (reset),
    .sym_emp   (sym_emp),
    .sym_data  (sym_data),
    .sym_rd    (sym_rd),
    .res       (res),
    .res_neg   (res_neg),
    .res_valid (res_valid),
    .err       (err),
    .busy      (busy)
  );

  always #10 CLK_50M = ~CLK_50M;

  logic [3:0] fmem [512];
  int wr_ptr    = 0;
  int rd_ptr    = 0;
  int cyc       = 0;
  int eq_cyc    = -1;
  bit prev_rd   = 1'b0;
  bit back2back = 1'b0;
  int n_checks  = 0;
  int n_pass    = 0;

  // FIFO read side: pop on sym_rd, note when '=' is consumed, count cycles
  always @(posedge CLK_50M) begin
    if (sym_rd) begin
      if (prev_rd) back2back = 1'b1;
      if (sym_data == 4'hE) eq_cyc = cyc;
      rd_ptr = rd_ptr + 1;
    end
    prev_rd = sym_rd;
    cyc = cyc + 1;
  end

  // FIFO head presentation, updated just after every clock edge
  always begin
    @(CLK_50M);
    #1;
    sym_emp  = (rd_ptr == wr_ptr);
    sym_data = (rd_ptr == wr_ptr) ? 4'h0 : fmem[rd_ptr];
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_outs(input string tag, input int e_res, input int e_neg,
                            input int e_valid, input int e_err);
    check({tag, ":res"},   int'(res),       e_res);
    check({tag, ":neg"},   int'(res_neg),   e_neg);
    check({tag, ":valid"}, int'(res_valid), e_valid);
    check({tag, ":err"},   int'(err),       e_err);
  endtask

  task automatic feed(input string s, output int start_cyc);
    @(negedge CLK_50M);
    start_cyc = cyc;
    for (int i = 0; i < s.len(); i++) begin
      int c = int'(s[i]);
      fmem[wr_ptr] = 4'((c >= 65) ? (c - 55) : (c - 48));
      wr_ptr++;
    end
  endtask

  // Waits for the first res_valid/err after an '=' popped since start_cyc
  task automatic wait_result(input string tag, input int start_cyc,
                             output int lat, output int nbusy);
    lat   = -1;
    nbusy = 0;
    for (int n = 0; n < 60 && lat < 0; n++) begin
      @(negedge CLK_50M);
      if (busy) nbusy++;
      if (eq_cyc >= start_cyc && cyc > eq_cyc && (res_valid || err)) lat = cyc - eq_cyc;
    end
    check({tag, ":completed"}, int'(lat >= 0), 1);
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 100 && rd_ptr != wr_ptr; n++) @(negedge CLK_50M);
    repeat (3) @(negedge CLK_50M);
    check({tag, ":drained"}, int'(rd_ptr == wr_ptr), 1);
  endtask

  task automatic run(input string tag, input string s, input int e_res, input int e_neg,
                     input int e_valid, input int e_err, input int e_lat, input int e_busy);
    int st, lat, nb;
    feed(s, st);
    wait_result(tag, st, lat, nb);
    check_outs(tag, e_res, e_neg, e_valid, e_err);
    check({tag, ":latency"}, lat, e_lat);
    check({tag, ":busy_cycles"}, nb, e_busy);
  endtask

  initial begin
    int st;
    repeat (3) @(negedge CLK_50M);
    check_outs("reset", 0, 0, 0, 0);
    check("reset:busy", int'(busy), 0);
    check("reset:sym_rd", int'(sym_rd), 0);
    reset = 1'b0;

    // Addition, then subtraction with a negative result, then a forbidden chain
    run("add_12_34", "12A34E", 46, 0, 1, 0, 2, 1);
    check("no_back_to_back_pop", int'(back2back), 0);
    run("sub_5_9", "5B9E", 4, 1, 1, 0, 2, 1);
    feed("C2E", st);
    drain("neg_chain");
    check_outs("neg_chain", 0, 0, 0, 1);
    feed("F", st);
    drain("clr1");
    check_outs("clr1", 0, 0, 0, 0);
    check("clr1:busy", int'(busy), 0);

    // Multiply at the top of the range and just past it
    run("mul_15_17", "15C17E", 255, 0, 1, 0, 9, 8);
    run("mul_16_16", "16C16E", 0, 0, 0, 1, 9, 8);
    feed("F", st);
    drain("clr2");

    // Division, divide by zero, symbols ignored in ERR
    run("div_200_7", "200D7E", 28, 0, 1, 0, 9, 8);
    run("div_7_0", "7D0E", 0, 0, 0, 1, 9, 8);
    feed("3E9", st);
    drain("err_hold");
    check("err_hold:err", int'(err), 1);
    feed("F", st);
    drain("clr3");
    check("clr3:err", int'(err), 0);

    // Chaining from a positive result, and further boundary cases
    run("add_3_4", "3A4E", 7, 0, 1, 0, 2, 1);
    run("chain_mul_2", "C2E", 14, 0, 1, 0, 9, 8);
    run("sub_9_5", "9B5E", 4, 0, 1, 0, 2, 1);
    run("add_255_0", "255A0E", 255, 0, 1, 0, 2, 1);
    run("add_200_100", "200A100E", 0, 0, 0, 1, 2, 1);
    feed("F", st);
    drain("clr4");
    run("last_op_wins", "8AB3E", 5, 0, 1, 0, 2, 1);
    feed("E", st);
    drain("eq_in_fin");
    check_outs("eq_in_fin", 5, 0, 1, 0);

    // Reset while the multiplier is running
    feed("15C17E", st);
    for (int n = 0; n < 40 && !busy; n++) @(negedge CLK_50M);
    check("mid_mul:busy_seen", int'(busy), 1);
    check("mid_mul:res_before", int'(res), 5);
    reset = 1'b1;
    fmem[wr_ptr] = 4'd5;
    wr_ptr++;
    #2;
    check("mid_rst:sym_rd_in_reset", int'(sym_rd), 0);
    @(negedge CLK_50M);
    check_outs("mid_rst", 0, 0, 0, 0);
    check("mid_rst:busy", int'(busy), 0);
    reset = 1'b0;
    #2;
    check("mid_rst:sym_rd_after", int'(sym_rd), 0);
    drain("post_rst");

    // Operand entry limits
    feed("F1234", st);
    drain("too_many_digits");
    check("too_many_digits:err", int'(err), 1);
    feed("F260", st);
    drain("operand_ovf");
    check("operand_ovf:err", int'(err), 1);
    feed("F", st);
    drain("clr5");
    check_outs("clr5", 0, 0, 0, 0);
    check("final_no_back_to_back_pop", int'(back2back), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
